// File: rtl/point_double_seq.sv
// point_double_seq
//   Sequential Jacobian point doubling on y^2 = x^3 + 7 over GF(P). All seven
//   products share one MSB-first bit-serial interleaved modular multiplier
//   (1 setup cycle + WIDTH iteration cycles per product). Modular add, sub
//   and doubling are combinational and only feed a multiplier setup cycle or
//   the FIN cycle. Latency from start-accept to done is 7*(WIDTH+1)+2 cycles
//   for every operand value.
//
//   Optional feature: define POINT_DOUBLE_RANGE_CHECK_EN to reject operands
//   >= P. A rejected request goes straight to DONE with err=1 and zero
//   outputs. Without the macro, err is tied to 0.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request one doubling (sampled only in IDLE)
//   x1, y1, z1   Jacobian input point, captured on start-accept
//   busy         high from the cycle after accept through the done cycle
//   done         one-cycle pulse when x3/y3/z3/err are valid
//   x3, y3, z3   doubled point, fully reduced, held until the next done
//   err          rejected operand flag (range-check builds only)
module point_double_seq #(
  parameter int unsigned       WIDTH = 256,
  parameter logic [WIDTH-1:0]  P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] z1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] z3,
  output logic             err
);

  localparam int unsigned      CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

  // Operands are < P. Comparing a against P-b decides the wrap without ever
  // forming a WIDTH+1 bit sum.
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    t = P - b;
    return (a >= t) ? (a - t) : (a + b);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (a + (P - b));
  endfunction

  function automatic logic [WIDTH-1:0] dbl_mod(input logic [WIDTH-1:0] a);
    return add_mod(a, a);
  endfunction

  state_t           state;
  logic             setup;
  logic [2:0]       step;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] mul_a, mul_b, acc;
  logic [WIDTH-1:0] x1r, y1r, z1r;
  logic [WIDTH-1:0] ra, rb, rc, rt, ryz, rd, re, rf, rx3;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] s3, d_val, e_val, x3_val, dmx;
  logic [WIDTH-1:0] acc2, acc_n;
  logic [WIDTH-1:0] y3_fin, z3_fin;

  always_comb begin
    s3     = add_mod(x1r, rb);
    d_val  = dbl_mod(sub_mod(sub_mod(rt, ra), rc));
    e_val  = add_mod(dbl_mod(ra), ra);
    x3_val = sub_mod(rf, dbl_mod(rd));
    dmx    = sub_mod(rd, x3_val);

    op_a = x1r;
    op_b = x1r;
    case (step)
      3'd1: begin op_a = y1r;   op_b = y1r;   end
      3'd2: begin op_a = rb;    op_b = rb;    end
      3'd3: begin op_a = s3;    op_b = s3;    end
      3'd4: begin op_a = y1r;   op_b = z1r;   end
      3'd5: begin op_a = e_val; op_b = e_val; end
      3'd6: begin op_a = re;    op_b = dmx;   end
      default: ;
    endcase

    // acc <- 2*acc + bit*a, each stage reduced by one conditional subtract
    acc2  = dbl_mod(acc);
    acc_n = mul_b[WIDTH-1] ? add_mod(acc2, mul_a) : acc2;

    y3_fin = sub_mod(acc, dbl_mod(dbl_mod(dbl_mod(rc))));
    z3_fin = dbl_mod(ryz);
  end

`ifdef POINT_DOUBLE_RANGE_CHECK_EN
  logic reject;
  assign reject = (x1 >= P) || (y1 >= P) || (z1 >= P);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      setup <= 1'b1;
      step  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      x3    <= '0;
      y3    <= '0;
      z3    <= '0;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x1r   <= x1;
            y1r   <= y1;
            z1r   <= z1;
            busy  <= 1'b1;
            step  <= '0;
            setup <= 1'b1;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
            if (reject) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              x3    <= '0;
              y3    <= '0;
              z3    <= '0;
            end else begin
              state <= MUL;
            end
`else
            state <= MUL;
`endif
          end
        end

        MUL: begin
          if (setup) begin
            mul_a <= op_a;
            mul_b <= op_b;
            acc   <= '0;
            cnt   <= '0;
            setup <= 1'b0;
            // D and E are latched in step 5 so step 6 can derive X3 from F
            if (step == 3'd5) begin
              rd <= d_val;
              re <= e_val;
            end
            if (step == 3'd6) rx3 <= x3_val;
          end else begin
            acc   <= acc_n;
            mul_b <= {mul_b[WIDTH-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
              setup <= 1'b1;
              case (step)
                3'd0: ra  <= acc_n;
                3'd1: rb  <= acc_n;
                3'd2: rc  <= acc_n;
                3'd3: rt  <= acc_n;
                3'd4: ryz <= acc_n;
                3'd5: rf  <= acc_n;
                default: ;  // E*(D-X3) stays in acc for FIN
              endcase
              if (step == 3'd6) state <= FIN;
              else              step  <= step + 3'd1;
            end
          end
        end

        FIN: begin
          x3    <= rx3;
          y3    <= y3_fin;
          z3    <= z3_fin;
          done  <= 1'b1;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
          err   <= 1'b0;
`endif
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_double_seq.sv
// tb_point_double_seq
//   Randomized and directed bench for point_double_seq (WIDTH=256, secp256k1
//   prime). A behavioural model computes the doubled point with wide
//   arithmetic and '%', and tracks busy/done/err/output timing per cycle.
module tb_point_double_seq;

  localparam logic [255:0] PR  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] GX2 = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] GY2 = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
  localparam int           LAT = 7 * (256 + 1) + 2;

  logic         clk, reset, start;
  logic [255:0] x1, y1, z1;
  logic         busy, done, err;
  logic [255:0] x3, y3, z3;

  point_double_seq #(.WIDTH(256), .P(PR)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x1(x1), .y1(y1), .z1(z1),
    .busy(busy), .done(done),
    .x3(x3), .y3(y3), .z3(z3),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, PR};
    return t[255:0];
  endfunction

  function automatic logic [255:0] ad(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} + {256'd0, b}) % {256'd0, PR};
    return t[255:0];
  endfunction

  function automatic logic [255:0] sb(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = ({256'd0, a} + {256'd0, PR} - {256'd0, b}) % {256'd0, PR};
    return t[255:0];
  endfunction

  // Doubling formula for a = 0, straight from the curve arithmetic
  task automatic pdbl(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                      output logic [255:0] xo, output logic [255:0] yo, output logic [255:0] zo);
    logic [255:0] a, b, c, d, e, f, t;
    a  = mm(x, x);
    b  = mm(y, y);
    c  = mm(b, b);
    t  = ad(x, b);
    t  = mm(t, t);
    d  = sb(sb(t, a), c);
    d  = ad(d, d);
    e  = mm(256'd3, a);
    f  = mm(e, e);
    xo = sb(f, ad(d, d));
    yo = sb(mm(e, sb(d, xo)), mm(256'd8, c));
    zo = mm(256'd2, mm(y, z));
  endtask

  function automatic logic [255:0] rnd_fe();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    if (r >= PR) r = r - PR;
    return r;
  endfunction

  // ---------------- cycle-level behavioural model ----------------
  logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_ov = 1'b1;
  logic [255:0] m_x3 = '0, m_y3 = '0, m_z3 = '0;
  logic [255:0] p_x, p_y, p_z;
  logic         p_ov, rc_reject;
  int           m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ov = 1'b1;
      m_x3 = '0; m_y3 = '0; m_z3 = '0; m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_err  = 1'b0;
        m_x3 = p_x; m_y3 = p_y; m_z3 = p_z;
        m_ov = p_ov;
      end
    end else if (start) begin
      m_busy    = 1'b1;
      p_ov      = (x1 < PR) && (y1 < PR) && (z1 < PR);
      rc_reject = 1'b0;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
      rc_reject = !p_ov;
`endif
      if (rc_reject) begin
        m_done = 1'b1;
        m_err  = 1'b1;
        m_x3 = '0; m_y3 = '0; m_z3 = '0;
        m_ov = 1'b1;
      end else begin
        pdbl(x1, y1, z1, p_x, p_y, p_z);
        m_left = LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 256'(busy), 256'(m_busy));
      chk("done", 256'(done), 256'(m_done));
      chk("err",  256'(err),  256'(m_err));
      if (m_ov) begin
        chk("x3", x3, m_x3);
        chk("y3", y3, m_y3);
        chk("z3", z3, m_z3);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed / random driver ----------------
  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    for (int n = 1; n <= LAT + 300; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk("latency", 256'(lat), 256'(exp_lat));
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                        input int exp_lat);
    x1 = x; y1 = y; z1 = z;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(exp_lat);
  endtask

  logic [255:0] ex, ey, ez, px, py, pz, qx, qy, qz, lam, l2;
  int           dones, dcnt, k;

  initial begin
    reset = 1'b1; start = 1'b0;
    x1 = '0; y1 = '0; z1 = '0;

    // pin the model against known values
    pdbl(GX, GY, 256'd1, ex, ey, ez);
    chk("model_g_x", mm(GX2, mm(ez, ez)), ex);
    chk("model_g_y", mm(GY2, mm(ez, mm(ez, ez))), ey);
    pdbl(256'd1, 256'd1, 256'd0, ex, ey, ez);
    chk("model_inf_x", ex, 256'd1);
    chk("model_inf_y", ey, 256'd1);
    chk("model_inf_z", ez, 256'd0);

    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_x3", x3, 256'd0);
    @(posedge clk); #1;

    // generator
    run_op(GX, GY, 256'd1, LAT);
    chk("g_x3_affine", x3, mm(GX2, mm(z3, z3)));
    chk("g_y3_affine", y3, mm(GY2, mm(z3, mm(z3, z3))));
    chk("g_err", 256'(err), 256'd0);

    // point at infinity encoding
    run_op(256'd1, 256'd1, 256'd0, LAT);
    chk("inf_x3", x3, 256'd1);
    chk("inf_y3", y3, 256'd1);
    chk("inf_z3", z3, 256'd0);
    chk("inf_err", 256'(err), 256'd0);

    // extra start pulses while busy and in the done cycle
    x1 = GX; y1 = GY; z1 = 256'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 1802; n++) begin
      if (done) dones++;
      if (n == 1801) chk("done_at_1801", 256'(done), 256'd1);
      start = (n == 5) || (n >= 1801);
      if (n == 5)    begin x1 = 256'd5; y1 = 256'd6; z1 = 256'd7; end
      if (n == 1801) begin x1 = 256'd1; y1 = 256'd1; z1 = 256'd0; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("single_done", 256'(dones), 256'd1);
    chk("held_x3_affine", x3, mm(GX2, mm(z3, z3)));
    wait_done(LAT);
    chk("restart_x3", x3, 256'd1);
    chk("restart_z3", z3, 256'd0);

    // reset mid-operation
    x1 = GX; y1 = GY; z1 = 256'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < 900; n++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 256'(busy), 256'd0);
    chk("abort_done", 256'(done), 256'd0);
    chk("abort_err",  256'(err),  256'd0);
    chk("abort_x3", x3, 256'd0);
    chk("abort_y3", y3, 256'd0);
    chk("abort_z3", z3, 256'd0);
    dcnt = 0;
    repeat (2000) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no_done_after_abort", 256'(dcnt), 256'd0);

    // operand equal to P
    x1 = PR; y1 = 256'd2; z1 = 256'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef POINT_DOUBLE_RANGE_CHECK_EN
    wait_done(1);
    chk("range_err", 256'(err), 256'd1);
    chk("range_x3", x3, 256'd0);
    chk("range_y3", y3, 256'd0);
    chk("range_z3", z3, 256'd0);
`else
    wait_done(LAT);
    chk("range_err", 256'(err), 256'd0);
`endif

    // Y1 = 0 and Z1 = 0 with random other coordinates
    run_op(rnd_fe(), 256'd0, rnd_fe(), LAT);
    chk("y0_z3", z3, 256'd0);
    run_op(rnd_fe(), rnd_fe(), 256'd0, LAT);
    chk("z0_z3", z3, 256'd0);

    // random curve points (multiples of G) in random Jacobian scale
    px = GX; py = GY; pz = 256'd1;
    for (int v = 0; v < 12; v++) begin
      k = $urandom_range(1, 3);
      repeat (k) pdbl(px, py, pz, px, py, pz);
      lam = rnd_fe();
      if (lam == '0) lam = 256'd1;
      l2 = mm(lam, lam);
      qx = mm(px, l2);
      qy = mm(py, mm(l2, lam));
      qz = mm(pz, lam);
      pdbl(qx, qy, qz, ex, ey, ez);
      run_op(qx, qy, qz, LAT);
      chk("rnd_aff_x", mm(x3, mm(ez, ez)), mm(ex, mm(z3, z3)));
      chk("rnd_aff_y", mm(y3, mm(ez, mm(ez, ez))), mm(ey, mm(z3, mm(z3, z3))));
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
